// File: rtl/paddle_ctrl.sv
// Paddle position controller: single steps on button presses, then auto-repeat
// after a hold delay while the button stays down. Position clamps at both limits.
module paddle_ctrl #(
    parameter int Y_MIN    = 0,
    parameter int Y_MAX    = 520,
    parameter int Y_INIT   = 260,
    parameter int STEP     = 8,
    parameter int HOLD_DLY = 25_000_000,
    parameter int RPT_PER  = 2_500_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btnu,
    input  logic        btnd,
    output logic [10:0] paddle_y,
    output logic        at_top,
    output logic        at_bottom,
    output logic        moving
);

    localparam int CNT_MAX = (HOLD_DLY > RPT_PER) ? HOLD_DLY : RPT_PER;
    localparam int CNT_W   = $clog2(CNT_MAX);

    localparam logic [10:0] Y_MIN_V  = 11'(Y_MIN);
    localparam logic [10:0] Y_MAX_V  = 11'(Y_MAX);
    localparam logic [10:0] Y_INIT_V = 11'(Y_INIT);
    localparam logic [10:0] STEP_V   = 11'(STEP);
    localparam logic [11:0] Y_MAX_W  = 12'(Y_MAX);
    localparam logic [11:0] STEP_W   = 12'(STEP);
    localparam logic [11:0] UP_LIM_W = 12'(Y_MIN + STEP);

    localparam logic [CNT_W-1:0] HOLD_TC = CNT_W'(HOLD_DLY - 1);
    localparam logic [CNT_W-1:0] RPT_TC  = CNT_W'(RPT_PER - 1);

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

    state_t             state, state_nxt;
    logic               dir, dir_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [10:0]        y_nxt;
    logic [10:0]        y_up, y_dn;
    logic [11:0]        y_ext, y_sum;
    logic               dir_lvl, opp_lvl;

    // Compare before subtracting so the up step can never wrap below zero.
    assign y_ext = {1'b0, paddle_y};
    assign y_sum = y_ext + STEP_W;
    assign y_up  = (y_ext >= UP_LIM_W) ? (paddle_y - STEP_V) : Y_MIN_V;
    assign y_dn  = (y_sum > Y_MAX_W) ? Y_MAX_V : y_sum[10:0];

    assign dir_lvl = dir ? btnd : btnu;
    assign opp_lvl = dir ? btnu : btnd;

    // NOTE: every signal written here gets a default first; a path that skips
    // an assignment would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        dir_nxt   = dir;
        cnt_nxt   = cnt;
        y_nxt     = paddle_y;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (btn_up && !btn_down && !btnd) begin
                    y_nxt     = y_up;
                    dir_nxt   = 1'b0;
                    state_nxt = HOLD;
                end else if (btn_down && !btn_up && !btnu) begin
                    y_nxt     = y_dn;
                    dir_nxt   = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD, REPEAT: begin
                if (!dir_lvl || opp_lvl) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else if (cnt == ((state == HOLD) ? HOLD_TC : RPT_TC)) begin
                    y_nxt     = dir ? y_dn : y_up;
                    cnt_nxt   = '0;
                    state_nxt = REPEAT;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            dir       <= 1'b0;
            cnt       <= '0;
            paddle_y  <= Y_INIT_V;
            moving    <= 1'b0;
            at_top    <= (Y_INIT_V == Y_MIN_V);
            at_bottom <= (Y_INIT_V == Y_MAX_V);
        end else begin
            state     <= state_nxt;
            dir       <= dir_nxt;
            cnt       <= cnt_nxt;
            paddle_y  <= y_nxt;
            moving    <= (y_nxt != paddle_y);
            at_top    <= (y_nxt == Y_MIN_V);
            at_bottom <= (y_nxt == Y_MAX_V);
        end
    end

endmodule

// File: tb/tb_paddle_ctrl.sv
// Scoreboard bench for paddle_ctrl: a hold-time reference model predicts each
// cycle's outputs, a monitor compares them; directed scenarios plus random traffic.
module tb_paddle_ctrl;

    localparam int Y_MIN    = 0;
    localparam int Y_MAX    = 64;
    localparam int Y_INIT   = 32;
    localparam int STEP     = 8;
    localparam int HOLD_DLY = 4;
    localparam int RPT_PER  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        btn_up = 1'b0, btn_down = 1'b0, btnu = 1'b0, btnd = 1'b0;
    logic [10:0] paddle_y;
    logic        at_top, at_bottom, moving;

    paddle_ctrl #(
        .Y_MIN(Y_MIN), .Y_MAX(Y_MAX), .Y_INIT(Y_INIT), .STEP(STEP),
        .HOLD_DLY(HOLD_DLY), .RPT_PER(RPT_PER)
    ) dut (
        .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down),
        .btnu(btnu), .btnd(btnd), .paddle_y(paddle_y),
        .at_top(at_top), .at_bottom(at_bottom), .moving(moving)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [10:0] y;
        logic        top;
        logic        bot;
        logic        mov;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: position plus how long the active button has been held.
    int m_y = Y_INIT;
    bit m_act = 0;
    bit m_dir = 0;
    int m_k = 0;
    bit m_mov = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int move(input int y, input bit d);
        if (d) return (y + STEP > Y_MAX) ? Y_MAX : y + STEP;
        return (y - STEP < Y_MIN) ? Y_MIN : y - STEP;
    endfunction

    function automatic void model(input bit r, input bit bu, input bit bd,
                                  input bit lu, input bit ld);
        int  ny;
        bit  lvl, opp;
        if (r) begin
            m_y = Y_INIT; m_act = 0; m_dir = 0; m_k = 0; m_mov = 0;
            return;
        end
        ny = m_y;
        if (m_act) begin
            lvl = m_dir ? ld : lu;
            opp = m_dir ? lu : ld;
            if (lvl && !opp) begin
                m_k++;
                if (m_k == HOLD_DLY || (m_k > HOLD_DLY && (m_k - HOLD_DLY) % RPT_PER == 0))
                    ny = move(m_y, m_dir);
            end else begin
                m_act = 0;
            end
        end else if (bu && !bd && !ld) begin
            m_act = 1; m_dir = 0; m_k = 0; ny = move(m_y, 0);
        end else if (bd && !bu && !lu) begin
            m_act = 1; m_dir = 1; m_k = 0; ny = move(m_y, 1);
        end
        m_mov = (ny != m_y);
        m_y   = ny;
    endfunction

    // Apply inputs at a falling edge, predict, and return at the next falling edge.
    task automatic cyc(input bit r, input bit bu, input bit bd, input bit lu, input bit ld);
        exp_t e;
        rst = r; btn_up = bu; btn_down = bd; btnu = lu; btnd = ld;
        model(r, bu, bd, lu, ld);
        e.y   = 11'(m_y);
        e.top = (m_y == Y_MIN);
        e.bot = (m_y == Y_MAX);
        e.mov = m_mov;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_paddle_y", int'(paddle_y), int'(e.y));
                check("sb_at_top", int'(at_top), int'(e.top));
                check("sb_at_bottom", int'(at_bottom), int'(e.bot));
                check("sb_moving", int'(moving), int'(e.mov));
            end
        end
    end

    initial begin : stimulus
        int exp_y34[12] = '{40, 40, 40, 40, 48, 48, 56, 56, 64, 64, 64, 64};
        int exp_m34[12] = '{1, 0, 0, 0, 1, 0, 1, 0, 1, 0, 0, 0};
        bit lu, ld, bu, bd, r;

        @(negedge clk);

        // Reset then idle.
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        check("rst_y", int'(paddle_y), 32);
        check("rst_top", int'(at_top), 0);
        check("rst_bottom", int'(at_bottom), 0);
        check("rst_moving", int'(moving), 0);

        // Single up press, released after one cycle.
        cyc(0, 1, 0, 1, 0);
        check("press_up_y", int'(paddle_y), 24);
        check("press_up_moving", int'(moving), 1);
        cyc(0, 0, 0, 0, 0);
        check("press_up_moving_drop", int'(moving), 0);
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 0);
        check("press_up_no_more", int'(paddle_y), 24);

        // Down held 12 cycles: steps at 0, 4, 6, 8 and a clamped step at 10.
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) begin
            cyc(0, (i == 0) ? 1'b0 : 1'b0, (i == 0), 0, 1);
            check($sformatf("hold_dn_y_%0d", i), int'(paddle_y), exp_y34[i]);
            check($sformatf("hold_dn_mov_%0d", i), int'(moving), exp_m34[i]);
        end
        check("hold_dn_bottom", int'(at_bottom), 1);
        cyc(0, 0, 0, 0, 0);

        // Simultaneous pulses with both levels high: no step, stays idle.
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 1, 1, 1);
        check("both_y", int'(paddle_y), 32);
        check("both_moving", int'(moving), 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 0, 1, 0);
        check("both_then_idle_press", int'(paddle_y), 24);
        cyc(0, 0, 0, 0, 0);

        // Up held into repeat, then down level asserted: abort without step.
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 1, 0);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1, 0);
        check("rpt_up_y", int'(paddle_y), 8);
        cyc(0, 0, 0, 1, 1);
        check("opp_abort_y", int'(paddle_y), 8);
        check("opp_abort_moving", int'(moving), 0);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1, 0);
        check("opp_abort_frozen", int'(paddle_y), 8);

        // Reset in repeat at y=8, with a simultaneous up pulse.
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 1, 0);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1, 0);
        cyc(1, 1, 0, 1, 0);
        check("rst_in_rpt_y", int'(paddle_y), 32);
        check("rst_in_rpt_moving", int'(moving), 0);
        cyc(0, 1, 0, 1, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0);
        check("rst_cnt_cleared", int'(paddle_y), 24);
        cyc(0, 0, 0, 1, 0);
        check("rst_cnt_first_rpt", int'(paddle_y), 16);

        // Up held down to the top limit.
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 1, 0);
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 1, 0);
        check("top_y", int'(paddle_y), 0);
        check("top_flag", int'(at_top), 1);
        check("top_clamp_moving", int'(moving), 0);

        // Random traffic with persistent levels and sparse pulses/resets.
        lu = 0; ld = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 11) == 0) lu = ~lu;
            if ($urandom_range(0, 11) == 0) ld = ~ld;
            bu = ($urandom_range(0, 9) == 0);
            bd = ($urandom_range(0, 9) == 0);
            r  = ($urandom_range(0, 299) == 0);
            cyc(r, bu, bd, lu, ld);
        end
        cyc(0, 0, 0, 0, 0);

        @(posedge clk);
        #2;
        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/paddle_ctrl.md
PADDLE_CTRL -- requirements
Module: paddle_ctrl

Interface
REQ-001 Parameter Y_MIN, default 0: smallest legal paddle_y (top limit).
REQ-002 Parameter Y_MAX, default 520: largest legal paddle_y (bottom limit); Y_MAX > Y_MIN.
REQ-003 Parameter Y_INIT, default 260: paddle_y after reset; Y_MIN <= Y_INIT <= Y_MAX.
REQ-004 Parameter STEP, default 8: pixels moved per step; 1 <= STEP <= Y_MAX-Y_MIN.
REQ-005 Parameter HOLD_DLY, default 25_000_000: cycles a button is held before auto-repeat starts; >= 2.
REQ-006 Parameter RPT_PER, default 2_500_000: cycles between auto-repeat steps; >= 1.
REQ-007 clk  input  1  system clock; all logic on posedge.
REQ-008 rst  input  1  synchronous, active-high reset.
REQ-009 btn_up  input  1  one-cycle press pulse, up button (from btn_synchro).
REQ-010 btn_down  input  1  one-cycle press pulse, down button (from btn_synchro).
REQ-011 btnu  input  1  synchronised level, up button held.
REQ-012 btnd  input  1  synchronised level, down button held.
REQ-013 paddle_y  output  11  registered paddle top coordinate, unsigned.
REQ-014 at_top  output  1  registered, high when paddle_y == Y_MIN.
REQ-015 at_bottom  output  1  registered, high when paddle_y == Y_MAX.
REQ-016 moving  output  1  registered, high for exactly the cycle after paddle_y changed value.

Function
REQ-017 FSM states SHALL be IDLE, HOLD, REPEAT; plus a 1-bit direction register dir (0 = up, 1 = down).
REQ-018 Step up SHALL compute paddle_y = max(paddle_y - STEP, Y_MIN) without unsigned underflow (compare before subtract).
REQ-019 Step down SHALL compute paddle_y = min(paddle_y + STEP, Y_MAX), evaluated at 12 bits to avoid overflow.
REQ-020 IDLE: btn_up with btnd low -> step up, dir=0, counter cleared, go HOLD; btn_down with btnu low -> step down, dir=1, go HOLD.
REQ-021 IDLE: btn_up and btn_down in the same cycle, or a pulse while the opposite level is high -> no step, stay IDLE.
REQ-022 Press step latency: paddle_y SHALL show the new value on the clock edge sampling the pulse (visible the following cycle).
REQ-023 HOLD: counter increments each cycle the dir-button level is high; when counter reaches HOLD_DLY-1 -> one step in dir, counter cleared, go REPEAT.
REQ-024 REPEAT: counter increments each cycle; when counter reaches RPT_PER-1 -> one step in dir, counter cleared, stay REPEAT.
REQ-025 HOLD/REPEAT: dir-button level low, or opposite level high -> go IDLE, counter cleared, no step that cycle.
REQ-026 HOLD/REPEAT: new press pulses SHALL be ignored (no extra step).
REQ-027 At a limit, steps toward that limit SHALL leave paddle_y unchanged, moving stays low, FSM timing unaffected.
REQ-028 Counter width SHALL be $clog2(max(HOLD_DLY, RPT_PER)); no wrap-around occurs since it clears at terminal count.
REQ-029 at_top/at_bottom SHALL be updated in the same cycle as paddle_y (consistent with the registered value).

Reset
REQ-030 rst high SHALL force, on the next edge: paddle_y=Y_INIT, state=IDLE, dir=0, counter=0, moving=0, at_top=(Y_INIT==Y_MIN), at_bottom=(Y_INIT==Y_MAX).
REQ-031 rst SHALL override all inputs including a pulse in the same cycle; reset mid-HOLD/REPEAT aborts with no step.

Verification (bench params Y_MIN=0, Y_MAX=64, Y_INIT=32, STEP=8, HOLD_DLY=4, RPT_PER=2)
REQ-032 Reset, then idle -> paddle_y=32, at_top=0, at_bottom=0, moving=0.
REQ-033 btn_up pulse with btnu high 1 cycle then low -> paddle_y=24 next cycle, moving=1 one cycle, FSM back to IDLE, no further steps.
REQ-034 btnd held 12 cycles with initial btn_down pulse -> steps at cycles 0, 4, 6, 8, 10: paddle_y 40, 48, 56, 64, 64; at_bottom=1 from 64; moving low on the clamped step.
REQ-035 btn_up and btn_down in same cycle, both levels high -> paddle_y stays 32, state IDLE.
REQ-036 btnu held in REPEAT, btnd asserted -> IDLE next cycle, no step; paddle_y frozen.
REQ-037 rst asserted while in REPEAT at paddle_y=8 -> paddle_y=32, state IDLE, counter=0; a btn_up pulse in the rst cycle causes no step.
